keypad_scanner: RTL and testbench

Scanned-input counterpart to the board's multiplexed 7-segment driver. The driver strobes one-cold anodes and drives segment data; this block strobes one-cold columns of a 4x4 matrix keypad and reads the rows back. It debounces the full key matrix and emits one clean key event per press. Its 4-bit key code and strobe feed the game/control logic and the display path, which shows the value in decimal.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/scan_tick_gen.sv | 22 ++
 rtl/keypad_scanner.sv | 111 +++++++++++
 tb/tb_keypad_scanner.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kp_state_e;

  // Lowest set bit wins when several keys are down together.
  function automatic logic [KEY_W-1:0] lowest_set_index(input logic [NUM_KEYS-1:0] m);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (m[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column-step divider: one-cycle tick every TICK_DIV clocks.
module scan_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK50MHZ,
  input  logic RESET,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK50MHZ or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces whole-matrix frames and
// emits one key event per press-release cycle.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 8
) (
  input  logic       CLK50MHZ,
  input  logic       RESET,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  logic                tick;
  logic [3:0]          row_meta_q, row_sync_q;
  logic [3:0]          rows_pressed;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [3:0]          stable_q, stable_d;
  logic                frame_end, stable_valid;
  kp_state_e           state_q, state_d;
  logic [KEY_W-1:0]    code_q, code_d;

  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK50MHZ (CLK50MHZ),
    .RESET    (RESET),
    .tick     (tick)
  );

  assign rows_pressed = ~row_sync_q;
  assign frame_end    = tick && (col_idx_q == 2'd3);
  assign col_idx_d    = tick ? col_idx_q + 2'd1 : col_idx_q;
  assign COL          = ~(4'b0001 << col_idx_q);

  // Frame compare uses the snapshot including the column sampled this tick.
  always_comb begin
    snap_d   = snap_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    if (tick) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        snap_d[r*NUM_COLS + int'(col_idx_q)] = rows_pressed[r];
      end
    end
    if (frame_end) begin
      if (snap_d == prev_q) begin
        stable_d = (stable_q == DEB) ? stable_q : stable_q + 4'd1;
      end else begin
        stable_d = 4'd1;
        prev_d   = snap_d;
      end
    end
  end

  assign stable_valid = (stable_q == DEB);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    KEY_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        if (stable_valid && (|prev_q)) begin
          state_d   = PRESSED;
          code_d    = lowest_set_index(prev_q);
          KEY_VALID = 1'b1;
        end
      end
      PRESSED: begin
        if (stable_valid && !(|prev_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // New code is forwarded in the same cycle as the strobe.
  assign KEY_CODE = code_d;
  assign KEY_HELD = (state_q == PRESSED);

  always_ff @(posedge CLK50MHZ or posedge RESET) begin
    if (RESET) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      col_idx_q  <= '0;
      snap_q     <= '0;
      prev_q     <= '0;
      stable_q   <= '0;
      state_q    <= IDLE;
      code_q     <= '0;
    end else begin
      row_meta_q <= ROW;
      row_sync_q <= row_meta_q;
      col_idx_q  <= col_idx_d;
      snap_q     <= snap_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a modelled 4x4 key matrix.
module tb_keypad_scanner;

  localparam int FRAME = 16;
  localparam int LAT   = 3 * FRAME + 3 + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row, col, code;
  logic        kvalid, kheld;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_codes [0:255];
  int         obs_n = 0;
  int         rd = 0;

  keypad_scanner #(.CLK_HZ(40), .SCAN_HZ(10), .DEBOUNCE_FRAMES(2)) dut (
    .CLK50MHZ  (clk),
    .RESET     (rst),
    .ROW       (row),
    .COL       (col),
    .KEY_CODE  (code),
    .KEY_VALID (kvalid),
    .KEY_HELD  (kheld)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && kvalid) begin
      obs_codes[obs_n % 256] <= code;
      obs_n <= obs_n + 1;
    end
  end

  task automatic wait_pulse(input int budget, output int used);
    used = 0;
    while (obs_n == rd && used < budget) begin
      @(negedge clk);
      used++;
    end
  endtask

  task automatic wait_release(input int budget, output int used);
    used = 0;
    while (kheld && used < budget) begin
      @(negedge clk);
      used++;
    end
  endtask

  task automatic test_reset;
    logic [3:0] one, exp_col;
    one = 4'b0001;
    rst = 1'b1; keys = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1110 || code !== 4'd0 || kvalid !== 1'b0 || kheld !== 1'b0) begin
      errors++;
      $display("FAIL reset_state col=%b code=%0d valid=%b held=%b want 1110/0/0/0", col, code, kvalid, kheld);
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_col = ~(one << ((k / 4) % 4));
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("FAIL col_scan k=%0d got %b want %b", k, col, exp_col);
      end
    end
    checks++;
    if (obs_n !== 0 || kheld !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_event pulses=%0d held=%b want 0/0", obs_n, kheld);
    end
  endtask

  task automatic test_key6;
    int used;
    logic [3:0] e;
    keys = 16'h0040;
    exp_q.push_back(4'd6);
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL key6_timeout got no pulse within %0d cycles want code 6", LAT);
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL key6_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    @(negedge clk);
    checks++;
    if (kheld !== 1'b1) begin
      errors++;
      $display("FAIL key6_held got %b want 1", kheld);
    end
    keys = '0;
    wait_release(LAT, used);
    checks++;
    if (kheld !== 1'b0) begin
      errors++;
      $display("FAIL key6_release held=%b after %0d cycles want 0", kheld, used);
    end
    repeat (3 * FRAME) @(negedge clk);
    checks++;
    if (obs_n !== rd) begin
      errors++;
      $display("FAIL key6_extra pulses=%0d want %0d", obs_n, rd);
    end
  endtask

  task automatic test_bounce;
    int used;
    logic [3:0] e;
    exp_q.push_back(4'd9);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i % 3 == 0) keys[9] = ~keys[9];
      @(negedge clk);
    end
    keys = 16'h0200;
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL bounce_timeout got no pulse want code 9");
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL bounce_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    repeat (2 * FRAME) @(negedge clk);
    keys = '0;
    wait_release(LAT, used);
    repeat (3 * FRAME) @(negedge clk);
    checks++;
    if (obs_n !== rd || kheld !== 1'b0) begin
      errors++;
      $display("FAIL bounce_single pulses=%0d held=%b want %0d/0", obs_n, kheld, rd);
    end
  endtask

  task automatic test_multi;
    int used;
    logic [3:0] e;
    keys = 16'h1008;
    exp_q.push_back(4'd3);
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL multi_timeout got no pulse want code 3");
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL multi_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    keys = 16'h1000;
    repeat (5 * FRAME) @(negedge clk);
    checks++;
    if (obs_n !== rd || kheld !== 1'b1) begin
      errors++;
      $display("FAIL multi_partial pulses=%0d held=%b want %0d/1", obs_n, kheld, rd);
    end
    keys = '0;
    wait_release(LAT, used);
    checks++;
    if (kheld !== 1'b0 || obs_n !== rd) begin
      errors++;
      $display("FAIL multi_release held=%b pulses=%0d want 0/%0d", kheld, obs_n, rd);
    end
    repeat (FRAME) @(negedge clk);
    keys = 16'h1000;
    exp_q.push_back(4'd12);
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL multi_repress_timeout got no pulse want code 12");
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL multi_repress_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    keys = '0;
    wait_release(LAT, used);
    repeat (2 * FRAME) @(negedge clk);
  endtask

  task automatic test_glitch;
    keys = 16'h0001;
    repeat (FRAME) @(negedge clk);
    keys = '0;
    repeat (4 * FRAME) @(negedge clk);
    checks++;
    if (obs_n !== rd || kheld !== 1'b0) begin
      errors++;
      $display("FAIL glitch_key0 pulses=%0d held=%b want %0d/0", obs_n, kheld, rd);
    end
  endtask

  task automatic test_reset_mid;
    int used;
    logic [3:0] e;
    keys = 16'h8000;
    exp_q.push_back(4'd15);
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL rmid_timeout got no pulse want code 15");
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL rmid_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (col !== 4'b1110 || code !== 4'd0 || kvalid !== 1'b0 || kheld !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async col=%b code=%0d valid=%b held=%b want 1110/0/0/0", col, code, kvalid, kheld);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'd15);
    wait_pulse(LAT, used);
    checks++;
    if (obs_n == rd) begin
      errors++;
      $display("FAIL rmid_refresh_timeout got no pulse want code 15");
    end else begin
      e = exp_q.pop_front();
      if (obs_codes[rd % 256] !== e) begin
        errors++;
        $display("FAIL rmid_refresh_code got %0d want %0d", obs_codes[rd % 256], e);
      end
      rd++;
    end
    keys = '0;
    wait_release(LAT, used);
    checks++;
    if (kheld !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release held=%b want 0", kheld);
    end
  endtask

  initial begin
    rst = 1'b1;
    keys = '0;
    test_reset;
    test_key6;
    test_bounce;
    test_multi;
    test_glitch;
    test_reset_mid;
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || obs_n !== rd) begin
      errors++;
      $display("FAIL scoreboard_end pending=%0d pulses=%0d want 0/%0d", exp_q.size(), obs_n, rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
